shift_add_mac: RTL



---
 rtl/shift_add_mac_pkg.sv | 50 +++++
 rtl/shift_add_mac_lane.sv | 48 ++++
 rtl/shift_add_mac.sv | 115 +++++++++++
 3 files changed

// File: rtl/shift_add_mac_pkg.sv
// Shared types and elaboration-time helpers for the constant-weight MAC.
// Weights are split into signed power-of-two terms here.
package shift_add_mac_pkg;

  localparam int unsigned SA_DEPTH  = 3;
  localparam int unsigned MAX_TERMS = 32;

  // Each slot holds sign*(shift+1); a zero slot carries no term.
  typedef logic [MAX_TERMS-1:0][31:0] int_array;

  typedef enum logic {ACCUM, HOLD} mac_state_t;

  function automatic int abs_value(input int v);
    return (v < 0) ? -v : v;
  endfunction

  // Lowest canonical-signed digit of v: +1, -1 or 0.
  function automatic int determineOneShift(input int v);
    if ((v & 1) == 0) return 0;
    return ((v & 3) == 1) ? 1 : -1;
  endfunction

  function automatic int_array determineShifts(input int w);
    int_array terms;
    int v;
    int d;
    int n;
    terms = '0;
    v = w;
    n = 0;
    for (int s = 0; s < int'(MAX_TERMS); s++) begin
      d = determineOneShift(v);
      if (d != 0) begin
        terms[n] = 32'(d * (s + 1));
        n++;
      end
      v = (v - d) >>> 1;
    end
    return terms;
  endfunction

  function automatic int unsigned count_terms(input int_array terms);
    int unsigned n;
    n = 0;
    for (int t = 0; t < int'(MAX_TERMS); t++)
      if (terms[t] != '0) n++;
    return n;
  endfunction

endpackage

// File: rtl/shift_add_mac_lane.sv
// One lane: constant-weight product (shift-add or multiplier) and its
// stage-1 register.
module shift_add_mac_lane
  import shift_add_mac_pkg::*;
#(
  parameter int unsigned BITS   = 17,
  parameter int unsigned DEPTH  = SA_DEPTH,
  parameter int signed   WEIGHT = 256
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic [BITS-1:0]   x,
  output logic [2*BITS-1:0] p
);

  localparam int unsigned PW       = 2 * BITS;
  localparam int_array    TERMS    = determineShifts(WEIGHT);
  localparam int unsigned NTERMS   = count_terms(TERMS);
  localparam bit          USE_MULT = (NTERMS > DEPTH) ||
                                     (abs_value(WEIGHT) == (1 << (BITS - 1)));

  logic signed [PW-1:0] x_ext;
  logic signed [PW-1:0] prod_c;

  assign x_ext = PW'($signed(x));

  if (USE_MULT) begin : g_mult
    assign prod_c = x_ext * PW'(WEIGHT);
  end else begin : g_shift
    // Constant terms fold away; a zero weight leaves only the constant 0.
    always_comb begin
      prod_c = '0;
      for (int t = 0; t < int'(MAX_TERMS); t++) begin
        if ($signed(TERMS[t]) > 0)
          prod_c = prod_c + (x_ext <<< ($signed(TERMS[t]) - 1));
        else if ($signed(TERMS[t]) < 0)
          prod_c = prod_c - (x_ext <<< (-$signed(TERMS[t]) - 1));
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset)   p <= '0;
    else if (en) p <= prod_c;
  end

endmodule

// File: rtl/shift_add_mac.sv
// Multi-lane constant-weight dot product with NACC-beat accumulation,
// round-half-up, NFRAC shift and saturation; 3-stage stallable pipeline.
module shift_add_mac
  import shift_add_mac_pkg::*;
#(
  parameter int unsigned        NCH     = 4,
  parameter int unsigned        BITS    = 17,
  parameter int unsigned        NFRAC   = 8,
  parameter int unsigned        DEPTH   = SA_DEPTH,
  parameter int unsigned        NACC    = 1,
  parameter logic [NCH*BITS-1:0] WEIGHTS = {NCH{BITS'(256)}},
  parameter int unsigned        ACCW    = 2 * BITS + $clog2(NCH * NACC) + 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [NCH*BITS-1:0] data_in,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [BITS-1:0]     data_out,
  output logic                out_sat
);

  localparam int unsigned PW   = 2 * BITS;
  localparam int unsigned CNTW = (NACC > 1) ? $clog2(NACC) : 1;
  localparam logic signed [ACCW-1:0] RND =
    (NFRAC == 0) ? '0 : ACCW'(64'sd1 <<< (NFRAC - 1));
  localparam logic signed [ACCW-1:0] SAT_MAX = ACCW'((64'sd1 <<< (BITS - 1)) - 64'sd1);
  localparam logic signed [ACCW-1:0] SAT_MIN = ~SAT_MAX;

  mac_state_t             state;
  logic                   stall_c;
  logic                   lane_en_c;
  logic                   s1_valid;
  logic                   s2_valid;
  logic [PW-1:0]          prod [NCH];
  logic signed [ACCW-1:0] lane_sum_c;
  logic signed [ACCW-1:0] s2_sum;
  logic signed [ACCW-1:0] acc;
  logic signed [ACCW-1:0] acc_sum_c;
  logic signed [ACCW-1:0] rnd_c;
  logic [CNTW-1:0]        cnt;
  logic                   last_c;
  logic                   sat_hi_c;
  logic                   sat_lo_c;

  assign out_valid = (state == HOLD);
  assign stall_c   = out_valid & ~out_ready;
  assign in_ready  = ~stall_c;
  assign lane_en_c = in_valid & ~stall_c;

  // S1: per-lane constant products
  for (genvar i = 0; i < int'(NCH); i++) begin : g_lane
    localparam int signed W = 32'($signed(WEIGHTS[i*BITS +: BITS]));
    shift_add_mac_lane #(
      .BITS   (BITS),
      .DEPTH  (DEPTH),
      .WEIGHT (W)
    ) u_lane (
      .clk   (clk),
      .reset (reset),
      .en    (lane_en_c),
      .x     (data_in[i*BITS +: BITS]),
      .p     (prod[i])
    );
  end

  always_comb begin
    lane_sum_c = '0;
    for (int i = 0; i < int'(NCH); i++)
      lane_sum_c = lane_sum_c + ACCW'($signed(prod[i]));
  end

  // S3 arithmetic: accumulate, round half up, scale and range-check
  always_comb begin
    acc_sum_c = acc + s2_sum;
    rnd_c     = (acc_sum_c + RND) >>> NFRAC;
    last_c    = (cnt == CNTW'(NACC - 1));
    sat_hi_c  = (rnd_c > SAT_MAX);
    sat_lo_c  = (rnd_c < SAT_MIN);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
      s2_sum   <= '0;
      acc      <= '0;
      cnt      <= '0;
      data_out <= '0;
      out_sat  <= 1'b0;
      state    <= ACCUM;
    end else if (!stall_c) begin
      s1_valid <= in_valid;
      s2_valid <= s1_valid;
      s2_sum   <= lane_sum_c;
      if (s2_valid && last_c) begin
        acc      <= '0;
        cnt      <= '0;
        data_out <= sat_hi_c ? SAT_MAX[BITS-1:0] :
                    sat_lo_c ? SAT_MIN[BITS-1:0] : rnd_c[BITS-1:0];
        out_sat  <= sat_hi_c | sat_lo_c;
        state    <= HOLD;
      end else begin
        if (s2_valid) begin
          acc <= acc_sum_c;
          cnt <= cnt + 1'b1;
        end
        if (out_ready) state <= ACCUM;
      end
    end
  end

endmodule
